// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory port between the I-cache and
// D-cache fill engines. One transaction at a time, round-robin on ties,
// fixed-latency read return, saturating per-requester grant counters.
//
// state | meaning
// IDLE  | no transaction; arbitrate pending requests
// ISSUE | strobe driven with latched addr/data, waiting for mem_stall low
// WAIT  | strobe accepted; counting down the fixed memory latency
// DONE  | one-cycle completion pulse to the owner
module mem_arbiter #(
  parameter int MEM_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [15:0]      i_addr,
  output logic             i_done,
  output logic [15:0]      i_rdata,
  input  logic             d_req,
  input  logic             d_wr,
  input  logic [15:0]      d_addr,
  input  logic [15:0]      d_wdata,
  output logic             d_done,
  output logic [15:0]      d_rdata,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  input  logic             mem_stall,
  input  logic [15:0]      mem_rdata,
  output logic             busy,
  output logic             grant_d,
  output logic [CNT_W-1:0] i_grant_cnt,
  output logic [CNT_W-1:0] d_grant_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Counter reload: the capture cycle lands MEM_LAT cycles after acceptance.
  localparam logic [3:0]       WAIT_LOAD = 4'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  // Owner of the current transaction; after completion it doubles as the
  // last owner used for round-robin tie breaking (1 = D, 0 = I).
  logic             owner_q, owner_d;
  logic             wr_q, wr_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic [15:0]      i_rdata_q, i_rdata_d;
  logic [15:0]      d_rdata_q, d_rdata_d;
  logic [CNT_W-1:0] i_cnt_q, i_cnt_d;
  logic [CNT_W-1:0] d_cnt_q, d_cnt_d;
  logic             take_d;

  // State register and datapath registers; reset aborts any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= 16'h0000;
      wdata_q   <= 16'h0000;
      wcnt_q    <= 4'd0;
      i_rdata_q <= 16'h0000;
      d_rdata_q <= 16'h0000;
      i_cnt_q   <= '0;
      d_cnt_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wcnt_q    <= wcnt_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_cnt_q   <= i_cnt_d;
      d_cnt_q   <= d_cnt_d;
    end
  end

  // Next-state, grant decision, strobes and completion pulses.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wcnt_d    = wcnt_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_cnt_d   = i_cnt_q;
    d_cnt_d   = d_cnt_q;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    // D wins when alone, or on a tie when I held the port last.
    take_d    = d_req && (!i_req || !owner_q);

    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          owner_d = take_d;
          state_d = S_ISSUE;
          if (take_d) begin
            wr_d    = d_wr;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            if (d_cnt_q != '1) d_cnt_d = d_cnt_q + CNT_ONE;
          end else begin
            // I side only reads; write data bus keeps its last value.
            wr_d   = 1'b0;
            addr_d = i_addr;
            if (i_cnt_q != '1) i_cnt_d = i_cnt_q + CNT_ONE;
          end
        end
      end

      S_ISSUE: begin
        mem_rd = !wr_q;
        mem_wr = wr_q;
        if (!mem_stall) begin
          wcnt_d  = WAIT_LOAD;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (wcnt_q == 4'd0) begin
          if (!wr_q) begin
            if (owner_q) d_rdata_d = mem_rdata;
            else         i_rdata_d = mem_rdata;
          end
          state_d = S_DONE;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end

      S_DONE: begin
        i_done  = !owner_q;
        d_done  = owner_q;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign grant_d     = owner_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign i_grant_cnt = i_cnt_q;
  assign d_grant_cnt = d_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: requesters and a fixed-latency memory are modelled
// by the bench; expectations come from a transaction-level reference
// (round-robin order, completion cycle arithmetic, expected memory image).
module tb_mem_arbiter;
  localparam int L = 4;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_done;
  logic [15:0] i_rdata;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_done;
  logic [15:0] d_rdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_stall;
  logic [15:0] mem_rdata;
  logic        busy;
  logic        grant_d;
  logic [15:0] i_grant_cnt;
  logic [15:0] d_grant_cnt;

  logic        i_done4, d_done4, mem_rd4, mem_wr4, busy4, grant_d4;
  logic [15:0] i_rdata4, d_rdata4, mem_addr4, mem_wdata4;
  logic [3:0]  i_cnt4, d_cnt4;

  mem_arbiter #(.MEM_LAT(L), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_stall(mem_stall), .mem_rdata(mem_rdata),
    .busy(busy), .grant_d(grant_d),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
  );

  // Narrow-counter instance on the same inputs, for saturation.
  mem_arbiter #(.MEM_LAT(L), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done4), .i_rdata(i_rdata4),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done4), .d_rdata(d_rdata4),
    .mem_rd(mem_rd4), .mem_wr(mem_wr4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .mem_stall(mem_stall), .mem_rdata(mem_rdata),
    .busy(busy4), .grant_d(grant_d4),
    .i_grant_cnt(i_cnt4), .d_grant_cnt(d_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { bit wr; logic [15:0] addr; logic [15:0] wdata; } txn_t;
  typedef struct { int cyc; bit d; logic [15:0] rdata; } done_t;
  typedef struct { int cyc; bit wr; logic [15:0] addr; logic [15:0] wdata; } acc_t;
  typedef struct { int cyc; bit d; txn_t t; } inj_t;
  typedef struct { int cyc; logic [15:0] a; } alog_t;

  txn_t  iq[$], dq[$];
  inj_t  inj_q[$];
  int    stall_q[$];
  done_t done_log[$];
  acc_t  acc_log[$];
  int    strobe_cycles[$];
  alog_t addr_log[$];

  logic [15:0] mem_store [logic [15:0]];
  logic [15:0] exp_mem   [logic [15:0]];

  int          cyc, due, stall_left, scram_lo, scram_hi;
  logic [15:0] resp;
  bit          in_strobe, i_pop, d_pop;
  bit          exp_last_d;
  int          exp_i_cnt, exp_d_cnt;
  int          checks, errors;

  function automatic logic [15:0] init_word(logic [15:0] a);
    return (a * 16'd7) ^ 16'hC3A5;
  endfunction

  function automatic logic [15:0] mem_read(logic [15:0] a);
    return mem_store.exists(a) ? mem_store[a] : init_word(a);
  endfunction

  function automatic logic [15:0] exp_read(logic [15:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : init_word(a);
  endfunction

  task automatic clear_logs();
    done_log.delete(); acc_log.delete(); strobe_cycles.delete(); addr_log.delete();
  endtask

  // One clock of requesters + memory model; inputs driven #1 after the
  // rising edge, outputs sampled on the falling edge.
  task automatic step();
    @(posedge clk); #1;
    cyc++;
    if (i_pop && iq.size() > 0) iq.delete(0);
    if (d_pop && dq.size() > 0) dq.delete(0);
    i_pop = 0; d_pop = 0;
    while (inj_q.size() > 0 && inj_q[0].cyc <= cyc) begin
      if (inj_q[0].d) dq.push_back(inj_q[0].t); else iq.push_back(inj_q[0].t);
      inj_q.delete(0);
    end
    if (iq.size() > 0) begin i_req = 1; i_addr = iq[0].addr; end
    else begin i_req = 0; i_addr = 16'($urandom); end
    if (dq.size() > 0) begin
      d_req = 1; d_wr = dq[0].wr; d_addr = dq[0].addr; d_wdata = dq[0].wdata;
    end else begin
      d_req = 0; d_wr = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
    end
    if (cyc >= scram_lo && cyc <= scram_hi) begin
      d_wr = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
    end
    if ((mem_rd || mem_wr) && !in_strobe) begin
      in_strobe  = 1;
      stall_left = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
    end
    mem_stall = in_strobe && (stall_left > 0);
    mem_rdata = (cyc == due) ? resp : 16'($urandom);
    @(negedge clk);
    addr_log.push_back('{cyc, mem_addr});
    if (mem_rd || mem_wr) begin
      strobe_cycles.push_back(cyc);
      if (mem_stall) stall_left--;
      else begin
        in_strobe = 0;
        acc_log.push_back('{cyc, mem_wr, mem_addr, mem_wdata});
        if (mem_wr) mem_store[mem_addr] = mem_wdata;
        else begin due = cyc + L; resp = mem_read(mem_addr); end
      end
    end else begin
      in_strobe = 0;
    end
    if (i_done) begin done_log.push_back('{cyc, 1'b0, i_rdata}); i_pop = 1; end
    if (d_done) begin done_log.push_back('{cyc, 1'b1, d_rdata}); d_pop = 1; end
  endtask

  task automatic run_queues(input int max, output bit timeout);
    int n = 0;
    while ((iq.size() > 0 || dq.size() > 0 || inj_q.size() > 0) && n < max) begin
      step(); n++;
    end
    timeout = (n >= max);
    step();
  endtask

  task automatic reset_dut();
    @(posedge clk); #2;
    rst = 1;
    iq.delete(); dq.delete(); inj_q.delete(); stall_q.delete();
    i_pop = 0; d_pop = 0; i_req = 0; d_req = 0; mem_stall = 0;
    in_strobe = 0; due = -100;
    @(posedge clk); #1;
    rst = 0;
    exp_last_d = 0; exp_i_cnt = 0; exp_d_cnt = 0;
    clear_logs();
  endtask

  task automatic test_reset();
    #1 rst = 1;
    #1;
    checks++;
    if ({busy, mem_rd, mem_wr, i_done, d_done, grant_d} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000000", {busy, mem_rd, mem_wr, i_done, d_done, grant_d});
    end
    checks++;
    if ({i_rdata, d_rdata} !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h want 0", {i_rdata, d_rdata});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 32'h0) begin
      errors++; $display("FAIL reset_membus: got %h want 0", {mem_addr, mem_wdata});
    end
    checks++;
    if ({i_grant_cnt, d_grant_cnt, i_cnt4, d_cnt4} !== 40'h0) begin
      errors++; $display("FAIL reset_counts: got %h want 0", {i_grant_cnt, d_grant_cnt, i_cnt4, d_cnt4});
    end
    @(posedge clk); #1 rst = 0;
    exp_last_d = 0; exp_i_cnt = 0; exp_d_cnt = 0;
  endtask

  task automatic test_single_read();
    int c0; bit to;
    clear_logs();
    mem_store[16'h0040] = 16'hBEEF; exp_mem[16'h0040] = 16'hBEEF;
    iq.push_back('{1'b0, 16'h0040, 16'h0000});
    step(); c0 = cyc;
    run_queues(40, to); step();
    exp_i_cnt++; exp_last_d = 0;
    checks++; if (to) begin errors++; $display("FAIL single_timeout: got timeout want done"); end
    checks++;
    if (strobe_cycles.size() != 1 || strobe_cycles[0] != c0 + 1) begin
      errors++; $display("FAIL single_strobe: got n=%0d first=%0d want n=1 at %0d", strobe_cycles.size(), strobe_cycles[0] - c0, 1);
    end
    checks++;
    if (acc_log[0].wr !== 1'b0 || acc_log[0].addr !== 16'h0040) begin
      errors++; $display("FAIL single_bus: got wr=%b addr=%h want wr=0 addr=0040", acc_log[0].wr, acc_log[0].addr);
    end
    checks++;
    if (done_log.size() != 1 || done_log[0].cyc != c0 + 2 + L || done_log[0].d != 1'b0) begin
      errors++; $display("FAIL single_done: got n=%0d at %0d d=%b want n=1 at %0d d=0", done_log.size(), done_log[0].cyc - c0, done_log[0].d, 2 + L);
    end
    checks++;
    if (done_log[0].rdata !== 16'hBEEF || i_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL single_rdata: got %h/%h want beef", done_log[0].rdata, i_rdata);
    end
    checks++;
    if (i_grant_cnt !== 16'(exp_i_cnt) || d_grant_cnt !== 16'(exp_d_cnt)) begin
      errors++; $display("FAIL single_cnt: got %0d/%0d want %0d/%0d", i_grant_cnt, d_grant_cnt, exp_i_cnt, exp_d_cnt);
    end
  endtask

  task automatic test_stalled_write();
    int c0; bit to; logic [15:0] d_before;
    clear_logs();
    d_before = d_rdata;
    stall_q.push_back(3);
    dq.push_back('{1'b1, 16'h0100, 16'h1234});
    step(); c0 = cyc;
    run_queues(40, to); step();
    exp_d_cnt++; exp_last_d = 1; exp_mem[16'h0100] = 16'h1234;
    checks++; if (to) begin errors++; $display("FAIL wr_timeout: got timeout want done"); end
    checks++;
    if (strobe_cycles.size() != 4 || strobe_cycles[0] != c0 + 1 || strobe_cycles[3] != c0 + 4) begin
      errors++; $display("FAIL wr_strobe: got n=%0d first=%0d last=%0d want n=4 1..4", strobe_cycles.size(), strobe_cycles[0] - c0, strobe_cycles[3] - c0);
    end
    checks++;
    if (acc_log[0].wr !== 1'b1 || acc_log[0].addr !== 16'h0100 || acc_log[0].wdata !== 16'h1234) begin
      errors++; $display("FAIL wr_bus: got wr=%b %h<-%h want wr=1 0100<-1234", acc_log[0].wr, acc_log[0].addr, acc_log[0].wdata);
    end
    checks++;
    if (done_log.size() != 1 || done_log[0].cyc != c0 + 9 || done_log[0].d != 1'b1) begin
      errors++; $display("FAIL wr_done: got n=%0d at %0d d=%b want n=1 at 9 d=1", done_log.size(), done_log[0].cyc - c0, done_log[0].d);
    end
    checks++;
    if (d_rdata !== d_before) begin
      errors++; $display("FAIL wr_rdata_kept: got %h want %h", d_rdata, d_before);
    end
    checks++;
    if (d_grant_cnt !== 16'(exp_d_cnt) || grant_d !== 1'b1) begin
      errors++; $display("FAIL wr_cnt: got %0d gd=%b want %0d gd=1", d_grant_cnt, grant_d, exp_d_cnt);
    end
  endtask

  task automatic test_round_robin();
    int c0; bit to; bit exp_d; logic [15:0] ea;
    reset_dut();
    iq.push_back('{1'b0, 16'h0010, 16'h0}); iq.push_back('{1'b0, 16'h0011, 16'h0});
    dq.push_back('{1'b0, 16'h0020, 16'h0}); dq.push_back('{1'b0, 16'h0021, 16'h0});
    step(); c0 = cyc;
    run_queues(100, to); step();
    checks++; if (to) begin errors++; $display("FAIL rr_timeout: got timeout want done"); end
    checks++;
    if (done_log.size() != 4) begin
      errors++; $display("FAIL rr_count: got %0d want 4", done_log.size());
    end
    for (int k = 0; k < 4; k++) begin
      exp_d = (k % 2 == 0);
      ea = exp_d ? 16'h0020 + 16'(k / 2) : 16'h0010 + 16'(k / 2);
      checks++;
      if (done_log[k].d !== exp_d || done_log[k].cyc != c0 + 6 + 7 * k || done_log[k].rdata !== exp_read(ea)) begin
        errors++; $display("FAIL rr_txn%0d: got d=%b at %0d data %h want d=%b at %0d data %h",
                           k, done_log[k].d, done_log[k].cyc - c0, done_log[k].rdata, exp_d, 6 + 7 * k, exp_read(ea));
      end
    end
    exp_i_cnt = 2; exp_d_cnt = 2; exp_last_d = 0;
    checks++;
    if (i_grant_cnt !== 16'd2 || d_grant_cnt !== 16'd2) begin
      errors++; $display("FAIL rr_cnt: got %0d/%0d want 2/2", i_grant_cnt, d_grant_cnt);
    end
  endtask

  task automatic test_midwait_change();
    int c0, bad; bit to;
    clear_logs();
    dq.push_back('{1'b0, 16'h0200, 16'h0});
    step(); c0 = cyc;
    inj_q.push_back('{c0 + 3, 1'b0, '{1'b0, 16'h0300, 16'h0}});
    scram_lo = c0 + 1; scram_hi = c0 + 2 + L;
    run_queues(60, to); step();
    scram_lo = -1; scram_hi = -1;
    exp_d_cnt++; exp_i_cnt++; exp_last_d = 0;
    checks++; if (to) begin errors++; $display("FAIL mid_timeout: got timeout want done"); end
    bad = 0;
    foreach (addr_log[k]) if (addr_log[k].cyc >= c0 + 1 && addr_log[k].cyc <= c0 + 2 + L && addr_log[k].a !== 16'h0200) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL mid_addr_hold: got %0d bad cycles want 0", bad); end
    checks++;
    if (acc_log.size() != 2 || acc_log[0].wr !== 1'b0 || acc_log[0].addr !== 16'h0200 || acc_log[1].addr !== 16'h0300) begin
      errors++; $display("FAIL mid_bus: got n=%0d wr=%b a0=%h a1=%h want 2 0 0200 0300", acc_log.size(), acc_log[0].wr, acc_log[0].addr, acc_log[1].addr);
    end
    checks++;
    if (done_log[0].d !== 1'b1 || done_log[0].cyc != c0 + 6 || done_log[0].rdata !== exp_read(16'h0200)) begin
      errors++; $display("FAIL mid_d_done: got d=%b at %0d %h want d=1 at 6 %h", done_log[0].d, done_log[0].cyc - c0, done_log[0].rdata, exp_read(16'h0200));
    end
    checks++;
    if (done_log[1].d !== 1'b0 || done_log[1].cyc != c0 + 13 || done_log[1].rdata !== exp_read(16'h0300)) begin
      errors++; $display("FAIL mid_i_done: got d=%b at %0d %h want d=0 at 13 %h", done_log[1].d, done_log[1].cyc - c0, done_log[1].rdata, exp_read(16'h0300));
    end
  endtask

  task automatic test_reset_midwait();
    int c1; bit to;
    clear_logs();
    iq.push_back('{1'b0, 16'h0400, 16'h0});
    step();
    step(); step(); step();
    #1 rst = 1;
    #1;
    checks++;
    if ({busy, mem_rd, mem_wr, i_done, d_done, grant_d} !== 6'b0 || {i_rdata, d_rdata, mem_addr, mem_wdata} !== 64'h0) begin
      errors++; $display("FAIL rstmid_outputs: got ctl=%b data=%h want 0", {busy, mem_rd, mem_wr, i_done, d_done, grant_d}, {i_rdata, d_rdata, mem_addr, mem_wdata});
    end
    checks++;
    if (i_grant_cnt !== 16'd0 || d_grant_cnt !== 16'd0) begin
      errors++; $display("FAIL rstmid_cnt: got %0d/%0d want 0/0", i_grant_cnt, d_grant_cnt);
    end
    iq.delete(); i_pop = 0; in_strobe = 0;
    exp_i_cnt = 0; exp_d_cnt = 0; exp_last_d = 0;
    step();
    rst = 0;
    clear_logs();
    for (int k = 0; k < L + 4; k++) step();
    checks++;
    if (done_log.size() != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_log.size()); end
    iq.push_back('{1'b0, 16'h0401, 16'h0});
    step(); c1 = cyc;
    run_queues(40, to); step();
    exp_i_cnt = 1;
    checks++;
    if (to || done_log.size() != 1 || done_log[0].cyc != c1 + 2 + L || done_log[0].rdata !== exp_read(16'h0401)) begin
      errors++; $display("FAIL rstmid_next: got n=%0d at %0d %h want 1 at %0d %h", done_log.size(), done_log[0].cyc - c1, done_log[0].rdata, 2 + L, exp_read(16'h0401));
    end
    checks++;
    if (i_grant_cnt !== 16'd1) begin errors++; $display("FAIL rstmid_cnt2: got %0d want 1", i_grant_cnt); end
  endtask

  task automatic test_random();
    txn_t mi[$], md[$]; int st[$];
    txn_t tx; int ni, nd, c0, t, k, s, exp_done; bit to, take_d; logic [15:0] ev;
    for (int b = 0; b < 12; b++) begin
      mi.delete(); md.delete(); st.delete(); clear_logs();
      ni = $urandom_range(0, 3);
      nd = $urandom_range((ni == 0) ? 1 : 0, 3);
      for (int j = 0; j < ni; j++) begin
        tx.wr = 0; tx.addr = 16'h1000 + 16'($urandom_range(0, 15)); tx.wdata = 16'($urandom);
        iq.push_back(tx); mi.push_back(tx);
      end
      for (int j = 0; j < nd; j++) begin
        tx.wr = 1'($urandom_range(0, 1)); tx.addr = 16'h1000 + 16'($urandom_range(0, 15)); tx.wdata = 16'($urandom);
        dq.push_back(tx); md.push_back(tx);
      end
      for (int j = 0; j < ni + nd; j++) begin
        s = $urandom_range(0, 3); st.push_back(s); stall_q.push_back(s);
      end
      step(); c0 = cyc;
      run_queues(300, to); step();
      checks++; if (to) begin errors++; $display("FAIL rnd%0d_timeout: got timeout want done", b); end
      t = c0; k = 0;
      while (mi.size() > 0 || md.size() > 0) begin
        take_d = (md.size() > 0) && (mi.size() == 0 || !exp_last_d);
        tx = take_d ? md.pop_front() : mi.pop_front();
        exp_done = t + 2 + L + st[k];
        checks++;
        if (done_log[k].d !== take_d || done_log[k].cyc != exp_done) begin
          errors++; $display("FAIL rnd%0d_order%0d: got d=%b at %0d want d=%b at %0d", b, k, done_log[k].d, done_log[k].cyc - c0, take_d, exp_done - c0);
        end
        checks++;
        if (acc_log[k].wr !== tx.wr || acc_log[k].addr !== tx.addr || (tx.wr && acc_log[k].wdata !== tx.wdata)) begin
          errors++; $display("FAIL rnd%0d_bus%0d: got wr=%b %h/%h want wr=%b %h/%h", b, k, acc_log[k].wr, acc_log[k].addr, acc_log[k].wdata, tx.wr, tx.addr, tx.wdata);
        end
        if (tx.wr) exp_mem[tx.addr] = tx.wdata;
        else begin
          ev = exp_read(tx.addr);
          checks++;
          if (done_log[k].rdata !== ev) begin
            errors++; $display("FAIL rnd%0d_rdata%0d: got %h want %h", b, k, done_log[k].rdata, ev);
          end
        end
        if (take_d) exp_d_cnt++; else exp_i_cnt++;
        exp_last_d = take_d;
        t = exp_done + 1; k++;
      end
      checks++;
      if (done_log.size() != k || i_grant_cnt !== 16'(exp_i_cnt) || d_grant_cnt !== 16'(exp_d_cnt)) begin
        errors++; $display("FAIL rnd%0d_totals: got n=%0d cnt=%0d/%0d want n=%0d cnt=%0d/%0d", b, done_log.size(), i_grant_cnt, d_grant_cnt, k, exp_i_cnt, exp_d_cnt);
      end
    end
    checks++;
    if (i_cnt4 !== 4'((exp_i_cnt > 15) ? 15 : exp_i_cnt) || d_cnt4 !== 4'((exp_d_cnt > 15) ? 15 : exp_d_cnt)) begin
      errors++; $display("FAIL rnd_cnt4: got %0d/%0d want %0d/%0d", i_cnt4, d_cnt4, (exp_i_cnt > 15) ? 15 : exp_i_cnt, (exp_d_cnt > 15) ? 15 : exp_d_cnt);
    end
  endtask

  task automatic test_saturation();
    bit to;
    reset_dut();
    for (int j = 0; j < 17; j++) iq.push_back('{1'b0, 16'h2000 + 16'(j), 16'h0});
    run_queues(400, to); step();
    exp_i_cnt = 17;
    checks++;
    if (to || done_log.size() != 17) begin errors++; $display("FAIL sat_count: got %0d done want 17", done_log.size()); end
    checks++;
    if (i_cnt4 !== 4'd15 || d_cnt4 !== 4'd0) begin errors++; $display("FAIL sat_cnt4: got %0d/%0d want 15/0", i_cnt4, d_cnt4); end
    checks++;
    if (i_grant_cnt !== 16'(exp_i_cnt)) begin errors++; $display("FAIL sat_cnt16: got %0d want %0d", i_grant_cnt, exp_i_cnt); end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; due = -100; stall_left = 0;
    scram_lo = -1; scram_hi = -1; in_strobe = 0; i_pop = 0; d_pop = 0; resp = 16'h0;
    rst = 0; i_req = 0; i_addr = 16'h0; d_req = 0; d_wr = 0; d_addr = 16'h0; d_wdata = 16'h0;
    mem_stall = 0; mem_rdata = 16'h0;
    test_reset();
    test_single_read();
    test_stalled_write();
    test_round_robin();
    test_midwait_change();
    test_reset_midwait();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Arbitrates the single shared main-memory port between the I-cache and D-cache miss/fill engines of the pipelined processor. It accepts one transaction at a time, with round-robin priority on ties. It sequences the issue/wait/return of each transaction against the fixed-latency memory and reports per-requester grant counts for the perf log.

Parameters:
MEM_LAT, 4, cycles from accepted issue to valid mem_data_out (legal 1..15)
CNT_W, 16, width of saturating grant counters

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  reset, asynchronous, active-high
i_req  in  1  I-cache read request; held with i_addr until i_done
i_addr  in  16  I-cache word address
i_done  out  1  one-cycle pulse: I transaction complete, i_rdata valid this cycle
i_rdata  out  16  read data for I-cache (held until next I read completes)
d_req  in  1  D-cache request; held with d_wr/d_addr/d_wdata until d_done
d_wr  in  1  1=write, 0=read
d_addr  in  16  D-cache word address
d_wdata  in  16  D-cache write data
d_done  out  1  one-cycle pulse: D transaction complete
d_rdata  out  16  read data for D-cache (held until next D read completes)
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe
mem_addr  out  16  memory address
mem_wdata  out  16  memory write data
mem_stall  in  1  memory cannot accept a strobe this cycle
mem_rdata  in  16  memory read data, valid exactly MEM_LAT cycles after accepted read
busy  out  1  arbiter not in IDLE
grant_d  out  1  current/last owner is D (0 = I)
i_grant_cnt  out  CNT_W  number of I transactions granted, saturating
d_grant_cnt  out  CNT_W  number of D transactions granted, saturating

Behaviour:
- Reset (async, immediate): state=IDLE; all strobes, done pulses, busy=0; i_rdata=d_rdata=0; mem_addr=mem_wdata=0; counters=0; last_owner=I (so first tie goes to D).
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if no req, stay. If exactly one req, grant it. If both, grant the requester that is not last_owner. On grant: latch addr/wr/wdata into internal regs, set owner and last_owner, increment owner's counter (hold at all-ones), go to ISSUE.
- ISSUE: drive mem_rd (read) or mem_wr (write) =1 with latched addr/wdata. If mem_stall=1, stay and keep strobe high. If mem_stall=0, the strobe is accepted; load wait counter=MEM_LAT-1; go to WAIT.
- WAIT: strobes=0, mem_addr/mem_wdata hold. Decrement counter. When counter=0, and only for reads, capture mem_rdata into owner's rdata reg; go to DONE. The capture cycle is MEM_LAT cycles after the accepted strobe.
- DONE: pulse owner's done for exactly one cycle; rdata valid in that cycle; go to IDLE.
- Latency, no stall: req seen in IDLE at cycle 0 -> strobe cycle 1 -> capture cycle 1+MEM_LAT -> done cycle 2+MEM_LAT. Each stall cycle adds 1.
- Requester deasserts req in the cycle after done. A req still high in that IDLE cycle is treated as a new request.
- Requester inputs change while busy: ignored (latched copies used).
- Non-owner req held during a transaction: serviced in the next IDLE per round-robin. No starvation: with both continuously requesting, grants strictly alternate.
- Writes never modify i_rdata/d_rdata. I side never writes.
- busy=1 in ISSUE/WAIT/DONE.
- Reset mid-transaction: abort; any memory response in flight is ignored. No done pulse is generated.

Test Plan:
- MEM_LAT=4, single I read of 0x0040, mem returns 0xBEEF -> mem_rd high cycle 1 only, i_done cycle 6, i_rdata=0xBEEF, i_grant_cnt=1.
- D write 0x0100<-0x1234 with mem_stall high cycles 1-3 -> mem_wr high cycles 1-4, mem_wdata=0x1234; d_done cycle 9; d_rdata unchanged.
- i_req and d_req both at cycle 0, held continuously -> grant order D,I,D,I; each done pulse single-cycle; counters equal after 4 transactions.
- D read in flight, i_req rises mid-WAIT, d_addr changed mid-WAIT -> mem_addr stays at the original D address; I granted in the IDLE following d_done.
- rst asserted during WAIT of an I read -> outputs reset asynchronously, no i_done; the next request is serviced with normal latency.
- Force i_grant_cnt near max (CNT_W=4 override) with 17 I reads -> counter saturates at 15.
